tt_add_accum: RTL and testbench

- Parametrised successor to the combinational pin-level adder: a registered add/subtract/accumulate unit with valid/ready handshakes on both sides.
- Sits between the TT pin wrapper (operands from ui_in/uio_in, result to uo_out) and the project core.
- Adds width generalisation, an operating mode, a running accumulator with optional saturation, carry/borrow and saturation flags, and an accepted-operation counter.

---
 rtl/tt_add_pkg.sv | 26 ++
 rtl/tt_sat_add.sv | 32 +++
 rtl/tt_add_accum.sv | 162 ++++++++++++++++
 tb/tb_tt_add_accum.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_add_pkg.sv
// rtl/tt_add_pkg.sv - shared types and parameter checks for the add/accumulate unit
//
// Contents:
//   mode_e          operation select carried on the mode port
//   acc_width_ok    true when the accumulator is wide enough to hold an
//                   operand sum without loss (ACC_WIDTH >= WIDTH+1)
//   width_ok        true when the operand width is usable (WIDTH >= 2)

package tt_add_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_CLR = 2'b11
    } mode_e;

    function automatic bit acc_width_ok(input int width, input int acc_width);
        return acc_width >= width + 1;
    endfunction

    function automatic bit width_ok(input int width);
        return width >= 2;
    endfunction

endpackage

// File: rtl/tt_sat_add.sv
// rtl/tt_sat_add.sv - combinational adder with carry-in and optional clamp to all-ones
//
// Ports:
//   a, b      [W-1:0]  addends (unsigned)
//   c_in      1        carry-in
//   sat_en    1        1 = clamp sum to all-ones on carry-out
//   sum       [W-1:0]  sum, clamped when sat_flag is set
//   carry     1        carry out of bit W-1, reported before any clamping
//   sat_flag  1        sum was clamped

module tt_sat_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    input  logic         sat_en,
    output logic [W-1:0] sum,
    output logic         carry,
    output logic         sat_flag
);

    logic [W:0] full_sum;

    always_comb begin
        full_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
        carry    = full_sum[W];
        sat_flag = sat_en & full_sum[W];
        sum      = sat_flag ? {W{1'b1}} : full_sum[W-1:0];
    end

endmodule

// File: rtl/tt_add_accum.sv
// rtl/tt_add_accum.sv - registered add/subtract/accumulate unit with valid/ready on both sides
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   in_valid, in_ready   input beat handshake (in_ready = !out_valid || out_ready)
//   op_a, op_b [WIDTH]   unsigned operands
//   mode [2]             00 ADD, 01 SUB, 10 ACC, 11 CLR
//   out_valid, out_ready output beat handshake
//   result [ACC_WIDTH]   registered result
//   carry                ADD carry-out / SUB borrow / ACC carry before clamping
//   sat                  ACC result was clamped (only when SAT_EN=1)
//   acc [ACC_WIDTH]      running accumulator
//   op_count [CNT_WIDTH] accepted beats, wrapping

module tt_add_accum
    import tt_add_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter bit SAT_EN    = 1'b1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 carry,
    output logic                 sat,
    output logic [ACC_WIDTH-1:0] acc,
    output logic [CNT_WIDTH-1:0] op_count
);

    if (!acc_width_ok(WIDTH, ACC_WIDTH)) begin : g_acc_width_err
        $error("tt_add_accum: ACC_WIDTH must be at least WIDTH+1");
    end
    if (!width_ok(WIDTH)) begin : g_width_err
        $error("tt_add_accum: WIDTH must be at least 2");
    end

    logic                 out_valid_q;
    logic [ACC_WIDTH-1:0] result_q;
    logic                 carry_q;
    logic                 sat_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    mode_e                op_mode;
    logic                 accept;

    logic [WIDTH:0]       add_full;
    logic [WIDTH:0]       sub_full;
    logic [ACC_WIDTH-1:0] add_ext;
    logic [ACC_WIDTH-1:0] sub_ext;
    logic [ACC_WIDTH-1:0] ab_ext;

    logic [ACC_WIDTH-1:0] acc_sum;
    logic                 acc_carry;
    logic                 acc_sat;

    logic [ACC_WIDTH-1:0] nxt_result;
    logic                 nxt_carry;
    logic                 nxt_sat;
    logic [ACC_WIDTH-1:0] nxt_acc;

    assign op_mode  = mode_e'(mode);
    // Single output register, no skid: a new beat fits only when the current
    // one is absent or leaving this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        add_full = {1'b0, op_a} + {1'b0, op_b};
        // The top bit of the WIDTH+1 difference is set exactly when op_a < op_b.
        sub_full = {1'b0, op_a} - {1'b0, op_b};

        add_ext                = '0;
        add_ext[WIDTH-1:0]     = add_full[WIDTH-1:0];
        sub_ext                = '0;
        sub_ext[WIDTH-1:0]     = sub_full[WIDTH-1:0];
        // op_a + op_b always fits in WIDTH+1 <= ACC_WIDTH bits, so the three-way
        // accumulate reduces to a two-input add with no lost carry.
        ab_ext                 = '0;
        ab_ext[WIDTH:0]        = add_full;
    end

    tt_sat_add #(
        .W (ACC_WIDTH)
    ) u_acc_add (
        .a        (acc_q),
        .b        (ab_ext),
        .c_in     (1'b0),
        .sat_en   (SAT_EN),
        .sum      (acc_sum),
        .carry    (acc_carry),
        .sat_flag (acc_sat)
    );

    always_comb begin
        nxt_result = '0;
        nxt_carry  = 1'b0;
        nxt_sat    = 1'b0;
        nxt_acc    = acc_q;
        case (op_mode)
            MODE_ADD: begin
                nxt_result = add_ext;
                nxt_carry  = add_full[WIDTH];
            end
            MODE_SUB: begin
                nxt_result = sub_ext;
                nxt_carry  = sub_full[WIDTH];
            end
            MODE_ACC: begin
                nxt_acc    = acc_sum;
                nxt_result = acc_sum;
                nxt_carry  = acc_carry;
                nxt_sat    = acc_sat;
            end
            MODE_CLR: begin
                nxt_acc    = '0;
            end
            default: begin
                nxt_acc    = acc_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            sat_q       <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                result_q    <= nxt_result;
                carry_q     <= nxt_carry;
                sat_q       <= nxt_sat;
                acc_q       <= nxt_acc;
                cnt_q       <= cnt_q + CNT_WIDTH'(1);
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign sat       = sat_q;
    assign acc       = acc_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_tt_add_accum.sv
// tb/tb_tt_add_accum.sv - scoreboard bench for tt_add_accum (saturating and wrapping instances)

module tb_tt_add_accum;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [1:0]  mode;
    logic        out_ready;

    logic        in_ready1, out_valid1, carry1, sat1;
    logic [15:0] result1, acc1;
    logic [7:0]  cnt1;
    logic        in_ready2, out_valid2, carry2, sat2;
    logic [15:0] result2, acc2;
    logic [2:0]  cnt2;

    tt_add_accum #(.WIDTH(8), .ACC_WIDTH(16), .SAT_EN(1'b1), .CNT_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .op_a(op_a), .op_b(op_b), .mode(mode), .out_valid(out_valid1),
        .out_ready(out_ready), .result(result1), .carry(carry1), .sat(sat1),
        .acc(acc1), .op_count(cnt1)
    );

    tt_add_accum #(.WIDTH(8), .ACC_WIDTH(16), .SAT_EN(1'b0), .CNT_WIDTH(3)) u_dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .op_a(op_a), .op_b(op_b), .mode(mode), .out_valid(out_valid2),
        .out_ready(out_ready), .result(result2), .carry(carry2), .sat(sat2),
        .acc(acc2), .op_count(cnt2)
    );

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, CLR = 2'b11;

    typedef struct {
        logic [15:0] r1;
        logic        c1;
        logic        s1;
        logic [15:0] a1;
        logic [7:0]  n1;
        logic [15:0] r2;
        logic        c2;
        logic [15:0] a2;
        logic [2:0]  n2;
    } exp_t;

    exp_t        sbq[$];
    int          pop_cyc[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int unsigned m_cnt = 0;
    logic [15:0] m_acc2 = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Issue one beat; the saturating instance's expectations are hand values
    // passed in, the wrapping instance follows a plain 16-bit wrap model.
    task automatic send(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] r, input logic c, input logic s,
                        input logic [15:0] ac);
        exp_t        e;
        int unsigned t;
        int          w;
        mode = m; op_a = a; op_b = b; in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready1 && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready1) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
            in_valid = 1'b0;
            return;
        end
        m_cnt++;
        e.r1 = r; e.c1 = c; e.s1 = s; e.a1 = ac;
        e.n1 = m_cnt[7:0];
        e.n2 = m_cnt[2:0];
        case (m)
            ACC: begin
                t      = m_acc2 + a + b;
                e.c2   = t[16];
                m_acc2 = t[15:0];
                e.r2   = m_acc2;
            end
            CLR: begin
                m_acc2 = '0;
                e.r2   = '0;
                e.c2   = 1'b0;
            end
            default: begin
                e.r2 = r;
                e.c2 = c;
            end
        endcase
        e.a2 = m_acc2;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        mode = ADD; op_a = '0; op_b = '0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sbq.size() != 0 && w < 50) begin
            w++;
            @(negedge clk);
        end
        chk("drain_pending", sbq.size(), 0);
    endtask

    // Monitor: a beat is consumed at the edge following a negedge where
    // out_valid && out_ready holds.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid1 && out_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("result",     result1,    e.r1);
                chk("carry",      carry1,     e.c1);
                chk("sat",        sat1,       e.s1);
                chk("acc",        acc1,       e.a1);
                chk("op_count",   cnt1,       e.n1);
                chk("w_valid",    out_valid2, 1);
                chk("w_result",   result2,    e.r2);
                chk("w_carry",    carry2,     e.c2);
                chk("w_sat",      sat2,       0);
                chk("w_acc",      acc2,       e.a2);
                chk("w_op_count", cnt2,       e.n2);
                pop_cyc.push_back(cyc);
            end
        end
    end

    initial begin : stimulus
        int n;
        rst = 1'b1;
        out_ready = 1'b1;
        idle();
        #1;
        chk("rst_in_ready", in_ready1, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid1, 0);
        chk("rst_result",    result1,    0);
        chk("rst_carry",     carry1,     0);
        chk("rst_sat",       sat1,       0);
        chk("rst_acc",       acc1,       0);
        chk("rst_op_count",  cnt1,       0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(ADD, 8'hF0, 8'h20, 16'h0010, 1'b1, 1'b0, 16'h0000);
        send(SUB, 8'h05, 8'h07, 16'h00FE, 1'b1, 1'b0, 16'h0000);
        send(SUB, 8'h07, 8'h05, 16'h0002, 1'b0, 1'b0, 16'h0000);
        send(ADD, 8'hFF, 8'hFF, 16'h00FE, 1'b1, 1'b0, 16'h0000);
        send(ADD, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 16'h0000);
        send(SUB, 8'h00, 8'hFF, 16'h0001, 1'b1, 1'b0, 16'h0000);
        send(CLR, 8'h12, 8'h34, 16'h0000, 1'b0, 1'b0, 16'h0000);
        send(ACC, 8'hFF, 8'hFF, 16'h01FE, 1'b0, 1'b0, 16'h01FE);
        send(ACC, 8'hFF, 8'hFF, 16'h03FC, 1'b0, 1'b0, 16'h03FC);
        send(ACC, 8'hFF, 8'hFF, 16'h05FA, 1'b0, 1'b0, 16'h05FA);

        // Preload 0xFFF0: 128 * 0x1FE = 0xFF00, then + 0xF0.
        send(CLR, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 16'h0000);
        for (int k = 1; k <= 128; k++) begin
            send(ACC, 8'hFF, 8'hFF, 16'(k * 16'h01FE), 1'b0, 1'b0, 16'(k * 16'h01FE));
        end
        send(ACC, 8'hF0, 8'h00, 16'hFFF0, 1'b0, 1'b0, 16'hFFF0);
        send(ACC, 8'h10, 8'h10, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF);
        send(ACC, 8'h01, 8'h00, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF);
        send(ADD, 8'h01, 8'h02, 16'h0003, 1'b0, 1'b0, 16'hFFFF);
        send(CLR, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 16'h0000);
        idle();
        drain();

        // Backpressure: first beat stalls, second is held by upstream.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(ADD, 8'h03, 8'h04, 16'h0007, 1'b0, 1'b0, 16'h0000);
        mode = ADD; op_a = 8'h10; op_b = 8'h20; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready",  in_ready1,  0);
            chk("stall_out_valid", out_valid1, 1);
            chk("stall_result",    result1,    16'h0007);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(ADD, 8'h10, 8'h20, 16'h0030, 1'b0, 1'b0, 16'h0000);
        idle();
        drain();

        // Reset during a stalled ACC result.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(ACC, 8'h05, 8'h06, 16'h000B, 1'b0, 1'b0, 16'h000B);
        idle();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready",  in_ready1,  1);
        chk("mid_rst_out_valid", out_valid1, 0);
        chk("mid_rst_acc",       acc1,       0);
        chk("mid_rst_result",    result1,    0);
        chk("mid_rst_op_count",  cnt1,       0);
        chk("mid_rst_w_acc",     acc2,       0);
        chk("mid_rst_w_count",   cnt2,       0);
        sbq.delete();
        m_cnt = 0;
        m_acc2 = '0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Streaming: ten ACC beats of 1 on consecutive cycles.
        for (int i = 1; i <= 10; i++) begin
            send(ACC, 8'h01, 8'h00, 16'(i), 1'b0, 1'b0, 16'(i));
        end
        idle();
        drain();
        n = pop_cyc.size();
        if (n >= 10) begin
            chk("stream_span", pop_cyc[n-1] - pop_cyc[n-10], 9);
        end else begin
            chk("stream_beats", n, 10);
        end
        chk("final_acc",        acc1, 16'd10);
        chk("final_op_count",   cnt1, 8'd10);
        chk("final_w_op_count", cnt2, 3'd2);
        chk("final_out_valid",  out_valid1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
